// File: rtl/scs8hd_pgseq_4.sv
`default_nettype none
// ============================================================================
// Module   : scs8hd_pgseq_4
// Purpose  : Staged power-up / power-down sequencer for a bank of
//            scs8hd_bufbuf_16 drivers. Turns four driver groups on one at a
//            time (EN[0] first) and off in reverse order (EN[0] last), so the
//            in-rush current is spread over several steps. Data input A is
//            forwarded to X, which feeds the bank.
//
// Parameters:
//   STEP_CYC  CLK cycles between enable steps (1..255).
//
// Ports:
//   CLK     in   1  sequencer clock, rising edge active
//   RESETB  in   1  asynchronous, active-low reset
//   REQ     in   1  power request level (1 = bank on, 0 = bank off)
//   A       in   1  data destined for the buffer bank
//   EN      out  4  registered, thermometer-coded group enables
//   ACK     out  1  registered, high only while the bank is fully on
//   ISOB    out  1  registered isolation, active-low (SC_PGSEQ_ISO_EN only)
//   X       out  1  data to the bank (clamped low while isolated)
//
// Build option:
//   SC_PGSEQ_ISO_EN  when defined, adds the ISOB port/register and clamps X
//                    to A & ISOB. When undefined, X = A at all times.
//
// Revision : 1.0  initial release
// ============================================================================
module scs8hd_pgseq_4 #(
  parameter int unsigned STEP_CYC = 4
) (
  input  logic       CLK,
  input  logic       RESETB,
  input  logic       REQ,
  input  logic       A,
  output logic [3:0] EN,
  output logic       ACK,
`ifdef SC_PGSEQ_ISO_EN
  output logic       ISOB,
`endif
  output logic       X
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_OFF = 2'd0;
  localparam logic [1:0] S_UP  = 2'd1;
  localparam logic [1:0] S_ON  = 2'd2;
  localparam logic [1:0] S_DN  = 2'd3;

  // The step counter counts down from STEP_CYC-1; a step happens on the edge
  // that sees it at zero, giving exactly STEP_CYC edges between steps.
  localparam logic [7:0] CNT_RELOAD = 8'(STEP_CYC - 1);

  localparam logic [2:0] STG_MAX = 3'd4;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0] state_q, state_d;
  logic [2:0] stg_q,   stg_d;    // number of enabled groups, 0..4
  logic [7:0] cnt_q,   cnt_d;    // step counter
  logic [3:0] en_q,    en_d;
  logic       ack_q,   ack_d;
`ifdef SC_PGSEQ_ISO_EN
  logic       isob_q,  isob_d;
`endif

  // --------------------------------------------------------------------------
  // State register (plus stage/counter and registered outputs)
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q <= S_OFF;
      stg_q   <= 3'd0;
      cnt_q   <= 8'd0;
      en_q    <= 4'b0000;
      ack_q   <= 1'b0;
`ifdef SC_PGSEQ_ISO_EN
      isob_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      stg_q   <= stg_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
`ifdef SC_PGSEQ_ISO_EN
      isob_q  <= isob_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    stg_d   = stg_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_OFF: begin
        if (REQ) begin
          state_d = S_UP;
          stg_d   = 3'd1;
          cnt_d   = CNT_RELOAD;
        end
      end

      S_UP: begin
        if (!REQ) begin
          // Reversal wins over any pending step; stage is held.
          state_d = S_DN;
          cnt_d   = CNT_RELOAD;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (stg_q < STG_MAX) begin
          stg_d = stg_q + 3'd1;
          cnt_d = CNT_RELOAD;
        end else begin
          // All four groups have been on for a full step interval.
          state_d = S_ON;
        end
      end

      S_ON: begin
        if (!REQ) begin
          state_d = S_DN;
          stg_d   = STG_MAX;
          cnt_d   = CNT_RELOAD;
        end
      end

      S_DN: begin
        if (REQ) begin
          state_d = S_UP;
          cnt_d   = CNT_RELOAD;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (stg_q != 3'd0) begin
          stg_d = stg_q - 3'd1;
          cnt_d = CNT_RELOAD;
        end else begin
          state_d = S_OFF;
        end
      end

      default: begin
        // Unreachable encoding: fall back to the safe all-off condition.
        state_d = S_OFF;
        stg_d   = 3'd0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic (registered on the next edge, so outputs trail the state by
  // one cycle; this is what keeps ISOB low for a full step interval after
  // EN reaches 1111, and drops it a full interval before EN[3] falls).
  // --------------------------------------------------------------------------
  always_comb begin
    en_d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      en_d[i] = (stg_q > 3'(i));
    end
    ack_d = (state_q == S_ON);
`ifdef SC_PGSEQ_ISO_EN
    isob_d = (state_q == S_ON);
`endif
  end

  assign EN  = en_q;
  assign ACK = ack_q;

`ifdef SC_PGSEQ_ISO_EN
  assign ISOB = isob_q;
  // Bank input is clamped low unless the whole bank is up.
  assign X    = A & isob_q;
`else
  assign X    = A;
`endif

endmodule

`default_nettype wire

// File: tb/tb_scs8hd_pgseq_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_scs8hd_pgseq_4
// Purpose  : Self-checking bench for scs8hd_pgseq_4. Three instances with
//            STEP_CYC = 4, 3 and 1 share clock, reset and data input; each
//            has its own REQ. Honours SC_PGSEQ_ISO_EN for the ISOB port/X.
// Revision : 1.0  initial release
// ============================================================================
module tb_scs8hd_pgseq_4;

  localparam int S4 = 4;
  localparam int S3 = 3;
  localparam int S1 = 1;

  logic       CLK = 1'b0;
  logic       RESETB = 1'b0;
  logic       A = 1'b0;
  logic       REQ4 = 1'b0, REQ3 = 1'b0, REQ1 = 1'b0;
  logic [3:0] EN4, EN3, EN1;
  logic       ACK4, ACK3, ACK1;
  logic       X4, X3, X1;
`ifdef SC_PGSEQ_ISO_EN
  logic       ISOB4, ISOB3, ISOB1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  scs8hd_pgseq_4 #(.STEP_CYC(S4)) u4 (
    .CLK(CLK), .RESETB(RESETB), .REQ(REQ4), .A(A), .EN(EN4), .ACK(ACK4),
`ifdef SC_PGSEQ_ISO_EN
    .ISOB(ISOB4),
`endif
    .X(X4));

  scs8hd_pgseq_4 #(.STEP_CYC(S3)) u3 (
    .CLK(CLK), .RESETB(RESETB), .REQ(REQ3), .A(A), .EN(EN3), .ACK(ACK3),
`ifdef SC_PGSEQ_ISO_EN
    .ISOB(ISOB3),
`endif
    .X(X3));

  scs8hd_pgseq_4 #(.STEP_CYC(S1)) u1 (
    .CLK(CLK), .RESETB(RESETB), .REQ(REQ1), .A(A), .EN(EN1), .ACK(ACK1),
`ifdef SC_PGSEQ_ISO_EN
    .ISOB(ISOB1),
`endif
    .X(X1));

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic logic [3:0] therm(input int n);
    int k;
    k = (n < 0) ? 0 : ((n > 4) ? 4 : n);
    return 4'((1 << k) - 1);
  endfunction

  // Expected X given A and whether the bank is fully on (ISOB high).
  function automatic logic exp_x(input logic a, input logic on);
`ifdef SC_PGSEQ_ISO_EN
    return a & on;
`else
    return a;
`endif
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model for the STEP_CYC=3 instance: tracks the number of groups
  // on, the direction requested, and the age since the last stage change or
  // reversal. A step happens once age reaches S. Outputs trail by one edge.
  // --------------------------------------------------------------------------
  bit         mdl_on = 0;
  bit         m_active, m_up, m_on;
  int         m_stg, m_age;
  logic [3:0] m_en;
  logic       m_ack;

  task automatic model_reset();
    m_active = 0; m_up = 0; m_on = 0; m_stg = 0; m_age = 0;
    m_en = 4'b0000; m_ack = 1'b0;
  endtask

  task automatic model_edge(input logic req);
    m_en  = therm(m_stg);
    m_ack = m_on;
    if (!m_active) begin
      if (req) begin
        m_active = 1; m_up = 1; m_stg = 1; m_age = 0;
      end
    end else if (req != m_up) begin
      m_up = req; m_on = 0; m_age = 0;
    end else if (!m_on) begin
      m_age++;
      if (m_age >= S3) begin
        if (m_up) begin
          if (m_stg < 4) begin m_stg++; m_age = 0; end
          else m_on = 1;
        end else begin
          if (m_stg > 0) begin m_stg--; m_age = 0; end
          else m_active = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    if (mdl_on) model_edge(REQ3);
    #1;
  endtask

  task automatic do_reset();
    RESETB = 1'b0;
    REQ4 = 1'b0; REQ3 = 1'b0; REQ1 = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESETB = 1'b1;
    model_reset();
  endtask

  // --------------------------------------------------------------------------
  // Directed + randomized sequence
  // --------------------------------------------------------------------------
  initial begin
    int len;
    do_reset();

    // Reset state
    A = 1'b1;
    #1;
    chk("rst_en",  EN4, 4'b0000);
    chk("rst_ack", {3'b0, ACK4}, 4'b0000);
    chk("rst_x",   {3'b0, X4}, {3'b0, exp_x(1'b1, 1'b0)});
`ifdef SC_PGSEQ_ISO_EN
    chk("rst_isob", {3'b0, ISOB4}, 4'b0000);
`endif

    // Full up-ramp, S=4: EN after edge k = therm(1+(k-1)/S), ON after 1+4S
    @(posedge CLK); #1;
    REQ4 = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      step();
      chk($sformatf("up4_en_k%0d", k), EN4, (k < 1) ? 4'b0000 : therm(1 + (k - 1) / S4));
      chk($sformatf("up4_ack_k%0d", k), {3'b0, ACK4}, {3'b0, 1'(k >= 1 + 4 * S4)});
`ifdef SC_PGSEQ_ISO_EN
      chk($sformatf("up4_isob_k%0d", k), {3'b0, ISOB4}, {3'b0, 1'(k >= 1 + 4 * S4)});
`endif
    end
    for (int i = 0; i < 4; i++) begin
      A = 1'($urandom_range(0, 1));
      #1;
      chk("on_x_follows_a", {3'b0, X4}, {3'b0, A});
    end

    // Full down-ramp from ON, S=4
    REQ4 = 1'b0;
    for (int k = 0; k <= 21; k++) begin
      step();
      chk($sformatf("dn4_en_k%0d", k), EN4,
          (k < 1 + S4) ? 4'b1111 : therm(4 - (k - 1) / S4));
      chk($sformatf("dn4_ack_k%0d", k), {3'b0, ACK4}, {3'b0, 1'(k == 0)});
`ifdef SC_PGSEQ_ISO_EN
      chk($sformatf("dn4_isob_k%0d", k), {3'b0, ISOB4}, {3'b0, 1'(k == 0)});
`endif
    end
    // Back in OFF: a new request turns EN[0] on after one edge.
    REQ4 = 1'b1;
    step(); step();
    chk("off_restart_en", EN4, 4'b0001);

    // Asynchronous reset mid-UP with EN=0011
    do_reset();
    @(posedge CLK); #1;
    REQ4 = 1'b1;
    repeat (6) step();
    chk("pre_rst_en", EN4, 4'b0011);
    A = 1'b1;
    #2 RESETB = 1'b0;
    #1;
    chk("async_rst_en",  EN4, 4'b0000);
    chk("async_rst_ack", {3'b0, ACK4}, 4'b0000);
    chk("async_rst_x",   {3'b0, X4}, {3'b0, exp_x(1'b1, 1'b0)});
`ifdef SC_PGSEQ_ISO_EN
    chk("async_rst_isob", {3'b0, ISOB4}, 4'b0000);
`endif

    // Reversal, S=3: EN=0011 after edge 4, REQ drop sampled at edge 5
    do_reset();
    @(posedge CLK); #1;
    REQ3 = 1'b1;
    repeat (5) step();
    chk("rev_pre_en", EN3, 4'b0011);
    REQ3 = 1'b0;
    for (int j = 0; j <= 9; j++) begin
      step();
      chk($sformatf("rev_en_j%0d", j), EN3,
          (j < 4) ? 4'b0011 : ((j < 7) ? 4'b0001 : 4'b0000));
      chk($sformatf("rev_ack_j%0d", j), {3'b0, ACK3}, 4'b0000);
    end

    // S=1 boundary: ON after edge 5
    do_reset();
    @(posedge CLK); #1;
    REQ1 = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step();
      chk($sformatf("s1_en_k%0d", k), EN1, therm(k));
      chk($sformatf("s1_ack_k%0d", k), {3'b0, ACK1}, {3'b0, 1'(k >= 5)});
    end

    // S=1, REQ toggling every cycle holds the stage at 2
    do_reset();
    @(posedge CLK); #1;
    REQ1 = 1'b1;
    step(); step();
    for (int t = 0; t < 12; t++) begin
      REQ1 = ~REQ1;
      step();
      chk($sformatf("tog_en_t%0d", t), EN1, 4'b0011);
      chk($sformatf("tog_ack_t%0d", t), {3'b0, ACK1}, 4'b0000);
    end

    // Randomized REQ runs on the S=3 instance against the model
    do_reset();
    mdl_on = 1;
    for (int b = 0; b < 40; b++) begin
      REQ3 = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 18);
      for (int c = 0; c < len; c++) begin
        A = 1'($urandom_range(0, 1));
        step();
        chk("rnd_en",  EN3, m_en);
        chk("rnd_ack", {3'b0, ACK3}, {3'b0, m_ack});
        chk("rnd_x",   {3'b0, X3}, {3'b0, exp_x(A, m_ack)});
`ifdef SC_PGSEQ_ISO_EN
        chk("rnd_isob", {3'b0, ISOB3}, {3'b0, m_ack});
`endif
      end
    end
    mdl_on = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
